// File: rtl/blink_rate_decoder_pkg.sv
// Shared definitions for the LED blink receive path: rate codes, decoder
// state encoding and the default half-period values. The transmitter's
// counters use the same numbers.
package blink_rate_decoder_pkg;

    // Rate codes, numbered in the order of the switch settings.
    localparam logic [1:0] RATE_100HZ = 2'b00;
    localparam logic [1:0] RATE_50HZ  = 2'b01;
    localparam logic [1:0] RATE_10HZ  = 2'b10;
    localparam logic [1:0] RATE_1HZ   = 2'b11;

    // Nominal half-periods in system clocks at 25 MHz.
    localparam int unsigned DEF_HALF_100HZ = 125000;
    localparam int unsigned DEF_HALF_50HZ  = 250000;
    localparam int unsigned DEF_HALF_10HZ  = 1250000;
    localparam int unsigned DEF_HALF_1HZ   = 12500000;

    // Default acceptance window (+/-12.5%) and idle timeout (1 s).
    localparam int unsigned DEF_TOL_SHIFT = 3;
    localparam int unsigned DEF_TIMEOUT   = 25000000;
    localparam int unsigned DEF_CNT_W     = 32;

    localparam int unsigned NUM_RATES = 4;

    // IDLE: no edge seen yet. ARMED: a reference edge is known.
    // ACQUIRE: one matching interval, candidate class held. LOCKED: two or
    // more consecutive intervals of the same class.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Maps a table index onto its rate code. Index order equals code order,
    // so the lowest index has priority.
    function automatic logic [1:0] rate_of_index(input int unsigned idx);
        return idx[1:0];
    endfunction

endpackage

// File: rtl/blink_edge_sync.sv
// Brings the asynchronous blink line into the clock domain and flags every
// transition (both polarities) with a single-cycle pulse. The pulse appears
// three clocks after the input changes.
module blink_edge_sync
    import blink_rate_decoder_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_blink,
    output logic o_edge
);

    logic sync_meta;
    logic sync_stable;
    logic blink_dly;
    logic edge_q;

    // Two-flop synchronizer, a delayed copy for comparison and the
    // registered edge pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            blink_dly   <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_meta   <= i_blink;
            sync_stable <= sync_meta;
            blink_dly   <= sync_stable;
            edge_q      <= sync_stable ^ blink_dly;
        end
    end

    assign o_edge = edge_q;

endmodule

// File: rtl/blink_rate_decoder.sv
// Recovers the rate code of an LED blink waveform. The decoder measures the
// clocks between edges and compares each interval against the four nominal
// half-periods. Two consecutive intervals of the same class give lock. A
// silent line drops back to IDLE after TIMEOUT clocks.
module blink_rate_decoder
    import blink_rate_decoder_pkg::*;
#(
    parameter int unsigned HALF_100HZ = DEF_HALF_100HZ,
    parameter int unsigned HALF_50HZ  = DEF_HALF_50HZ,
    parameter int unsigned HALF_10HZ  = DEF_HALF_10HZ,
    parameter int unsigned HALF_1HZ   = DEF_HALF_1HZ,
    parameter int unsigned TOL_SHIFT  = DEF_TOL_SHIFT,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned CNT_W      = DEF_CNT_W
)(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_blink,
    output logic [1:0] o_rate_code,
    output logic       o_valid,
    output logic       o_active,
    output logic       o_error
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic                 edge_pulse;
    logic [CNT_W-1:0]     interval_cnt;
    logic                 timeout_hit;

    logic [CNT_W-1:0]     half_tbl [NUM_RATES];
    logic [NUM_RATES-1:0] class_hit;
    logic                 match_any;
    logic [1:0]           match_code;

    state_t               state_q;
    state_t               state_d;
    logic [1:0]           cand_q;
    logic [1:0]           cand_d;
    logic [1:0]           code_q;
    logic [1:0]           code_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 active_q;
    logic                 active_d;
    logic                 error_q;
    logic                 error_d;

    blink_edge_sync u_edge_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_blink (i_blink),
        .o_edge  (edge_pulse)
    );

    // Interval counter: restarts at 1 on each edge, so its value on the next
    // edge equals the clocks between the two edges. It stops at TIMEOUT so
    // that a long idle line cannot wrap back into a valid window.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            interval_cnt <= '0;
        end else if (edge_pulse) begin
            interval_cnt <= ONE_C;
        end else if (interval_cnt < TIMEOUT_C) begin
            interval_cnt <= interval_cnt + ONE_C;
        end
    end

    assign timeout_hit = (interval_cnt == TIMEOUT_C);

    // Nominal half-periods indexed by rate code.
    assign half_tbl[0] = CNT_W'(HALF_100HZ);
    assign half_tbl[1] = CNT_W'(HALF_50HZ);
    assign half_tbl[2] = CNT_W'(HALF_10HZ);
    assign half_tbl[3] = CNT_W'(HALF_1HZ);

    // Window comparators. The absolute difference avoids any signed
    // arithmetic, and both operands stay within CNT_W, so nothing wraps.
    for (genvar k = 0; k < NUM_RATES; k++) begin : g_window
        logic [CNT_W-1:0] abs_diff;
        logic [CNT_W-1:0] tolerance;

        assign abs_diff  = (interval_cnt >= half_tbl[k]) ? (interval_cnt - half_tbl[k])
                                                          : (half_tbl[k] - interval_cnt);
        assign tolerance = half_tbl[k] >> TOL_SHIFT;
        assign class_hit[k] = (abs_diff <= tolerance);
    end

    // Priority encode the comparator hits. A descending scan lets the
    // lowest matching code overwrite the others.
    always_comb begin
        match_any  = 1'b0;
        match_code = RATE_100HZ;
        for (int i = NUM_RATES - 1; i >= 0; i--) begin
            if (class_hit[i]) begin
                match_any  = 1'b1;
                match_code = rate_of_index(i);
            end
        end
    end

    // State and output registers. Everything visible outside is registered,
    // so the outputs change one clock after the edge pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cand_q   <= RATE_100HZ;
            code_q   <= RATE_100HZ;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    // Lock FSM. An edge always takes precedence over a timeout in the same
    // cycle. The error flag is a pulse, so it defaults low every cycle.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        code_d   = code_q;
        valid_d  = valid_q;
        active_d = active_q;
        error_d  = 1'b0;

        if (edge_pulse) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ARMED;
                    active_d = 1'b1;
                end
                ST_ARMED: begin
                    if (match_any) begin
                        state_d = ST_ACQUIRE;
                        cand_d  = match_code;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (match_any && (match_code == cand_q)) begin
                        state_d = ST_LOCKED;
                        code_d  = cand_q;
                        valid_d = 1'b1;
                    end else if (match_any) begin
                        cand_d  = match_code;
                    end else begin
                        state_d = ST_ARMED;
                        error_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match_any && (match_code == code_q)) begin
                        state_d = ST_LOCKED;
                    end else if (match_any) begin
                        state_d = ST_ACQUIRE;
                        cand_d  = match_code;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_ARMED;
                        valid_d = 1'b0;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_hit && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            active_d = 1'b0;
        end
    end

    assign o_rate_code = code_q;
    assign o_valid     = valid_q;
    assign o_active    = active_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Bench for blink_rate_decoder, built with short simulation half-periods.
// A behavioural model tracks the run of consecutive same-class intervals
// and predicts lock, code, activity and the error pulse after every edge.
module tb_blink_rate_decoder;

    localparam int H0      = 10;
    localparam int H1      = 20;
    localparam int H2      = 100;
    localparam int H3      = 1000;
    localparam int TSHIFT  = 2;
    localparam int TOUT    = 2000;

    logic       i_clock;
    logic       i_reset;
    logic       i_blink;
    logic [1:0] o_rate_code;
    logic       o_valid;
    logic       o_active;
    logic       o_error;

    int n_asserts = 0;
    int n_fail    = 0;
    int since     = 0;

    // Reference model state.
    bit         m_active;
    bit         m_valid;
    bit         m_error;
    logic [1:0] m_code;
    int         run_class;
    int         run_len;

    blink_rate_decoder #(
        .HALF_100HZ (H0),
        .HALF_50HZ  (H1),
        .HALF_10HZ  (H2),
        .HALF_1HZ   (H3),
        .TOL_SHIFT  (TSHIFT),
        .TIMEOUT    (TOUT),
        .CNT_W      (32)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_blink     (i_blink),
        .o_rate_code (o_rate_code),
        .o_valid     (o_valid),
        .o_active    (o_active),
        .o_error     (o_error)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Returns the lowest class whose window contains the gap, or -1.
    function automatic int classify(input int gap);
        int halves [4];
        halves = '{H0, H1, H2, H3};
        for (int k = 0; k < 4; k++) begin
            int d;
            d = (gap > halves[k]) ? gap - halves[k] : halves[k] - gap;
            if (d <= (halves[k] >> TSHIFT)) return k;
        end
        return -1;
    endfunction

    // Model update for an edge that arrives gap clocks after the previous one.
    task automatic model_edge(input int gap);
        int cls;
        m_error = 1'b0;
        if (!m_active || gap > TOUT) begin
            m_active = 1'b1;
            m_valid  = 1'b0;
            run_len  = 0;
        end else begin
            cls = classify(gap);
            if (cls < 0) begin
                m_error = 1'b1;
                run_len = 0;
            end else if (run_len > 0 && cls == run_class) begin
                run_len++;
            end else begin
                run_class = cls;
                run_len   = 1;
            end
            m_valid = (run_len >= 2);
            if (m_valid) m_code = 2'(run_class);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_valid   = 1'b0;
        m_error   = 1'b0;
        m_code    = 2'b00;
        run_class = 0;
        run_len   = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
        since += n;
    endtask

    task automatic check_output(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".valid"},  {1'b0, o_valid},  {1'b0, m_valid});
        check_output({tag, ".active"}, {1'b0, o_active}, {1'b0, m_active});
        check_output({tag, ".error"},  {1'b0, o_error},  {1'b0, m_error});
        check_output({tag, ".code"},   o_rate_code,      m_code);
    endtask

    // Toggle the line gap clocks after the previous toggle, then check the
    // registered outputs and confirm that the error pulse lasts one cycle.
    task automatic apply_stimulus(input string tag, input int gap);
        if (gap > since) tick(gap - since);
        i_blink = ~i_blink;
        since   = 0;
        model_edge(gap);
        tick(4);
        check_all(tag);
        tick(1);
        check_output({tag, ".err_off"}, {1'b0, o_error}, 2'b00);
    endtask

    // Assert reset mid-cycle, check outputs clear immediately, then release.
    task automatic do_reset(input string tag);
        #3;
        i_reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        i_blink = 1'b0;
        tick(3);
        i_reset = 1'b0;
        since   = 0;
    endtask

    initial begin
        int code;
        int reps;
        int gap;
        int halves [4];
        int junk [8];
        halves = '{H0, H1, H2, H3};
        junk   = '{13, 14, 30, 50, 70, 130, 740, 1300};

        i_reset = 1'b0;
        i_blink = 1'b0;
        model_reset();
        @(posedge i_clock);
        #1;
        do_reset("reset");

        $display("[TB] lock at 50 Hz");
        apply_stimulus("t1.arm", 20);
        apply_stimulus("t1.acq", 20);
        apply_stimulus("t1.lock", 20);
        apply_stimulus("t1.hold", 20);

        $display("[TB] 1 Hz then switch to 100 Hz");
        apply_stimulus("t2.a", 1000);
        apply_stimulus("t2.b", 1000);
        apply_stimulus("t2.c", 1000);
        apply_stimulus("t2.drop", 10);
        apply_stimulus("t2.relock", 10);

        $display("[TB] unmatched intervals");
        apply_stimulus("t3.a", 50);
        apply_stimulus("t3.b", 50);
        apply_stimulus("t3.c", 50);

        $display("[TB] jitter at window edges");
        apply_stimulus("t5.a", 10);
        apply_stimulus("t5.b", 10);
        apply_stimulus("t5.j8", 8);
        apply_stimulus("t5.j12", 12);
        apply_stimulus("t5.j8b", 8);
        apply_stimulus("t5.j7", 7);
        apply_stimulus("t5.j13", 13);

        $display("[TB] timeout boundaries");
        apply_stimulus("t7.arm", 10);
        apply_stimulus("t7.eq", TOUT);
        apply_stimulus("t7.over", TOUT + 1);

        $display("[TB] lock at 10 Hz then hold line");
        apply_stimulus("t4.a", 100);
        apply_stimulus("t4.b", 100);
        apply_stimulus("t4.c", 100);
        tick(TOUT + 3 - since);
        check_output("t4.pre_active", {1'b0, o_active}, 2'b01);
        check_output("t4.pre_valid",  {1'b0, o_valid},  2'b01);
        tick(1);
        m_active = 1'b0;
        m_valid  = 1'b0;
        run_len  = 0;
        check_all("t4.idle");
        apply_stimulus("t4.rearm", since + 10);

        $display("[TB] reset while locked");
        apply_stimulus("t6.a", 20);
        apply_stimulus("t6.b", 20);
        do_reset("t6.rst");
        apply_stimulus("t6.arm", 6);
        apply_stimulus("t6.acq", 100);
        apply_stimulus("t6.lock", 100);

        $display("[TB] randomized intervals");
        for (int r = 0; r < 30; r++) begin
            code = int'($urandom_range(0, 4));
            reps = int'($urandom_range(1, 3));
            for (int j = 0; j < reps; j++) begin
                if (code == 4) begin
                    gap = junk[$urandom_range(0, 7)];
                end else begin
                    gap = halves[code] - (halves[code] >> TSHIFT)
                          + int'($urandom_range(0, 2 * (halves[code] >> TSHIFT)));
                end
                apply_stimulus($sformatf("rnd%0d.%0d", r, j), gap);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
